// File: rtl/spi_sub_xfer_ctrl.sv
// SPI sub-node transfer controller: turns synchronized SCLK/CS into
// shift, load and FIFO strobes, with sticky error flags.
module spi_sub_xfer_ctrl #(
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int DATA_WIDTH = 8
) (
    input  logic pclk,
    input  logic preset,
    input  logic sclk_i,
    input  logic cs_n_i,
    input  logic tx_empty,
    input  logic rx_full,
    input  logic clr_flags,
    output logic load_from_fifo,
    output logic slave_transfer_shift_en,
    output logic slave_receive_shift_en,
    output logic tx_pop,
    output logic rx_push,
    output logic busy,
    output logic tx_underrun,
    output logic rx_overrun,
    output logic frame_abort
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam bit SAMPLE_RISE = (CPOL == CPHA);
    localparam bit SCLK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        PUSH
    } state_t;

    state_t state, state_nxt;
    logic [CW-1:0] bit_cnt, cnt_nxt;
    logic sclk_q, cs_q, cs_armed;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic sample_edge, shift_edge;
    logic load_nxt, txs_nxt, rxs_nxt;
    logic push_nxt, und_set, ovr_set, abort_set;

    // cs_armed blocks a stale low CS seen right after reset from
    // looking like a fresh frame start.
    always_comb begin
        sclk_rise   = sclk_i & ~sclk_q;
        sclk_fall   = ~sclk_i & sclk_q;
        cs_fall     = cs_armed & cs_q & ~cs_n_i;
        cs_rise     = cs_n_i & ~cs_q;
        sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
        shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        load_nxt  = 1'b0;
        txs_nxt   = 1'b0;
        rxs_nxt   = 1'b0;
        abort_set = 1'b0;
        if (cs_n_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            abort_set = cs_rise && (state != IDLE) && (bit_cnt != '0);
        end else begin
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state_nxt = ACTIVE;
                        cnt_nxt   = '0;
                        load_nxt  = (CPHA == 0);
                    end
                end
                ACTIVE: begin
                    if (sample_edge) begin
                        rxs_nxt = 1'b1;
                        if (bit_cnt == LAST) begin
                            state_nxt = PUSH;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
                PUSH: state_nxt = ACTIVE;
                default: state_nxt = IDLE;
            endcase
            // A shift edge at bit 0 is the start of a new word.
            if ((state != IDLE) && shift_edge) begin
                if (bit_cnt == '0) begin
                    load_nxt = 1'b1;
                end else begin
                    txs_nxt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        push_nxt = (state == PUSH) && !rx_full;
        ovr_set  = (state == PUSH) && rx_full;
        und_set  = load_nxt && tx_empty;
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state                   <= IDLE;
            bit_cnt                 <= '0;
            sclk_q                  <= SCLK_IDLE;
            cs_q                    <= 1'b1;
            cs_armed                <= 1'b0;
            load_from_fifo          <= 1'b0;
            slave_transfer_shift_en <= 1'b0;
            slave_receive_shift_en  <= 1'b0;
            tx_pop                  <= 1'b0;
            rx_push                 <= 1'b0;
            tx_underrun             <= 1'b0;
            rx_overrun              <= 1'b0;
            frame_abort             <= 1'b0;
        end else begin
            state                   <= state_nxt;
            bit_cnt                 <= cnt_nxt;
            sclk_q                  <= sclk_i;
            cs_q                    <= cs_n_i;
            cs_armed                <= cs_armed | cs_n_i;
            load_from_fifo          <= load_nxt;
            slave_transfer_shift_en <= txs_nxt;
            slave_receive_shift_en  <= rxs_nxt;
            tx_pop                  <= load_nxt & ~tx_empty;
            rx_push                 <= push_nxt;
            tx_underrun             <= (tx_underrun & ~clr_flags) | und_set;
            rx_overrun              <= (rx_overrun & ~clr_flags) | ovr_set;
            frame_abort             <= (frame_abort & ~clr_flags) | abort_set;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_sub_xfer_ctrl.sv
// Directed bench: mode 0 and mode 3 instances driven by bit-banged
// SPI frames, strobe counters compared with hand-counted totals.
module tb_spi_sub_xfer_ctrl;

    logic pclk = 1'b0;
    logic preset = 1'b1;
    logic sclk0 = 1'b0, cs0 = 1'b1;
    logic sclk3 = 1'b1, cs3 = 1'b1;
    logic tx_empty = 1'b0, rx_full = 1'b0, clr_flags = 1'b0;

    logic ld0, txs0, rxs0, pop0, push0, busy0, und0, ovr0, abt0;
    logic ld3, txs3, rxs3, pop3, push3, busy3, und3, ovr3, abt3;

    int n_chk = 0;
    int n_fail = 0;

    int c_ld[2], c_txs[2], c_rxs[2], c_pop[2], c_push[2];
    logic cnt_clr = 1'b0;

    always #5 pclk = ~pclk;

    spi_sub_xfer_ctrl #(.CPOL(0), .CPHA(0), .DATA_WIDTH(8)) u_m0 (
        .pclk(pclk), .preset(preset), .sclk_i(sclk0), .cs_n_i(cs0),
        .tx_empty(tx_empty), .rx_full(rx_full), .clr_flags(clr_flags),
        .load_from_fifo(ld0), .slave_transfer_shift_en(txs0),
        .slave_receive_shift_en(rxs0), .tx_pop(pop0), .rx_push(push0),
        .busy(busy0), .tx_underrun(und0), .rx_overrun(ovr0),
        .frame_abort(abt0)
    );

    spi_sub_xfer_ctrl #(.CPOL(1), .CPHA(1), .DATA_WIDTH(8)) u_m3 (
        .pclk(pclk), .preset(preset), .sclk_i(sclk3), .cs_n_i(cs3),
        .tx_empty(tx_empty), .rx_full(rx_full), .clr_flags(clr_flags),
        .load_from_fifo(ld3), .slave_transfer_shift_en(txs3),
        .slave_receive_shift_en(rxs3), .tx_pop(pop3), .rx_push(push3),
        .busy(busy3), .tx_underrun(und3), .rx_overrun(ovr3),
        .frame_abort(abt3)
    );

    always @(negedge pclk) begin
        if (cnt_clr) begin
            for (int i = 0; i < 2; i++) begin
                c_ld[i] = 0; c_txs[i] = 0; c_rxs[i] = 0;
                c_pop[i] = 0; c_push[i] = 0;
            end
        end else begin
            c_ld[0] += int'(ld0);     c_ld[1] += int'(ld3);
            c_txs[0] += int'(txs0);   c_txs[1] += int'(txs3);
            c_rxs[0] += int'(rxs0);   c_rxs[1] += int'(rxs3);
            c_pop[0] += int'(pop0);   c_pop[1] += int'(pop3);
            c_push[0] += int'(push0); c_push[1] += int'(push3);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge pclk);
        #1;
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        @(negedge pclk);
        #1 cnt_clr = 1'b0;
        tick(1);
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        tick(1);
    endtask

    // Mode 0 bits; the last falling edge coincides with CS release
    // when end_cs is set.
    task automatic m0_bits(input int nbits, input bit end_cs);
        for (int i = 0; i < nbits; i++) begin
            sclk0 = 1'b1;
            tick(4);
            sclk0 = 1'b0;
            if (end_cs && i == nbits - 1) cs0 = 1'b1;
            tick(4);
        end
        tick(4);
    endtask

    task automatic m0_frame(input int nbits);
        cs0 = 1'b0;
        tick(4);
        m0_bits(nbits, 1'b1);
    endtask

    task automatic chk_counts(input string tag, input int d,
                              input int ld, input int txs, input int rxs,
                              input int pop, input int push);
        chk({tag, "_load"}, c_ld[d], ld);
        chk({tag, "_txs"}, c_txs[d], txs);
        chk({tag, "_rxs"}, c_rxs[d], rxs);
        chk({tag, "_pop"}, c_pop[d], pop);
        chk({tag, "_push"}, c_push[d], push);
    endtask

    initial begin
        tick(3);
        chk("rst_m0", {ld0, txs0, rxs0, pop0, push0, busy0, und0, ovr0, abt0}, 0);
        chk("rst_m3", {ld3, txs3, rxs3, pop3, push3, busy3, und3, ovr3, abt3}, 0);
        preset = 1'b0;
        tick(3);
        clr_cnt();

        // single mode 0 frame
        cs0 = 1'b0;
        tick(4);
        chk("m0_busy", busy0, 1);
        m0_bits(8, 1'b1);
        chk_counts("m0", 0, 1, 7, 8, 1, 1);
        chk("m0_flags", {und0, ovr0, abt0}, 0);
        chk("m0_idle", busy0, 0);

        // underrun on the initial load
        clr_cnt();
        tx_empty = 1'b1;
        cs0 = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        chk("und_load", ld0, 1);
        chk("und_pop", pop0, 0);
        chk("und_flag", und0, 1);
        tx_empty = 1'b0;
        tick(4);
        m0_bits(8, 1'b1);
        chk("und_sticky", und0, 1);
        pulse_clr();
        chk("und_clr", und0, 0);

        // overrun on the push
        clr_cnt();
        rx_full = 1'b1;
        m0_frame(8);
        rx_full = 1'b0;
        chk("ovr_push", c_push[0], 0);
        chk("ovr_flag", ovr0, 1);
        pulse_clr();
        chk("ovr_clr", ovr0, 0);

        // abort after 5 samples, then a clean frame
        clr_cnt();
        m0_frame(5);
        chk("abt_flag", abt0, 1);
        chk("abt_push", c_push[0], 0);
        chk("abt_idle", busy0, 0);
        pulse_clr();
        chk("abt_clr", abt0, 0);
        clr_cnt();
        m0_frame(8);
        chk_counts("post_abt", 0, 1, 7, 8, 1, 1);
        chk("post_abt_flag", abt0, 0);

        // reset mid-frame
        cs0 = 1'b0;
        tick(4);
        m0_bits(3, 1'b0);
        preset = 1'b1;
        tick(1);
        chk("rst_mid", {ld0, txs0, rxs0, pop0, push0, busy0, und0, ovr0, abt0}, 0);
        preset = 1'b0;
        clr_cnt();
        m0_bits(3, 1'b0);
        chk_counts("rst_hold", 0, 0, 0, 0, 0, 0);
        chk("rst_hold_busy", busy0, 0);
        chk("rst_hold_abt", abt0, 0);
        cs0 = 1'b1;
        tick(4);
        clr_cnt();
        m0_frame(8);
        chk_counts("rst_new", 0, 1, 7, 8, 1, 1);

        // mode 3, two frames under one CS
        clr_cnt();
        cs3 = 1'b0;
        tick(4);
        for (int i = 0; i < 16; i++) begin
            sclk3 = 1'b0;
            tick(4);
            sclk3 = 1'b1;
            tick(4);
        end
        tick(4);
        cs3 = 1'b1;
        tick(4);
        chk_counts("m3", 1, 2, 14, 16, 2, 2);
        chk("m3_flags", {und3, ovr3, abt3}, 0);
        chk("m3_idle", busy3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
